axis_dw_serializer: RTL and testbench

AXIS_DW_SERIALIZER -- requirements
Module: axis_dw_serializer

---
 rtl/dw_serializer_pkg.sv | 47 ++++
 rtl/dw_index_gen.sv | 64 ++++++
 rtl/axis_dw_serializer.sv | 180 ++++++++++++++++++
 tb/tb_axis_dw_serializer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dw_serializer_pkg.sv
// ============================================================================
// Module      : dw_serializer_pkg
// Description : Shared types for the AXI-Stream width serializer: FSM state
//               enum, member-index width function and user-field structs
//               laid out for the default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dw_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Width of a member index: ceil(log2(members)), at least 1.
  function automatic int dw_bm(input int members);
    int b;
    b = 1;
    while ((1 << b) < members) b++;
    return b;
  endfunction

  localparam int DEF_MEMBERS         = 12;
  localparam int DEF_CLR_WIDTH       = 4;
  localparam int DEF_USER_BASE_WIDTH = 8;
  localparam int DEF_BM              = dw_bm(DEF_MEMBERS);

  // Packed structs list MSB first, so base lands at bit 0.
  typedef struct packed {
    logic [DEF_MEMBERS-1:0][DEF_CLR_WIDTH-1:0] clr;
    logic [DEF_BM-1:0]                         count_1;
    logic [DEF_BM-1:0]                         step_1;
    logic [DEF_BM-1:0]                         first;
    logic [DEF_USER_BASE_WIDTH-1:0]            base;
  } s_user_t;

  typedef struct packed {
    logic [DEF_CLR_WIDTH-1:0]       clr;
    logic [DEF_BM-1:0]              idx;
    logic [DEF_USER_BASE_WIDTH-1:0] base;
  } m_user_t;

endpackage

`default_nettype wire

// File: rtl/dw_index_gen.sv
// ============================================================================
// Module      : dw_index_gen
// Description : Member index sequencer. Holds the current member index, the
//               beats-remaining counter and the stride; produces the modular
//               next index and the final-beat flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dw_index_gen
  import dw_serializer_pkg::*;
#(
  parameter int MEMBERS = 12,
  parameter int BM      = dw_bm(MEMBERS)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          load,
  input  logic [BM-1:0] first,
  input  logic [BM-1:0] step_1,
  input  logic [BM-1:0] count_1,
  input  logic          advance,
  output logic [BM-1:0] idx,
  output logic          final_beat
);

  localparam logic [BM:0]   C_MEMBERS = (BM+1)'(MEMBERS);
  localparam logic [BM:0]   C_ONE_W   = (BM+1)'(1);
  localparam logic [BM-1:0] C_ONE     = BM'(1);

  logic [BM-1:0] r_idx;
  logic [BM-1:0] r_step;
  logic [BM-1:0] r_rem;
  logic [BM:0]   w_sum;
  logic [BM:0]   w_wrapped;

  // Next index = idx + step_1 + 1, folded back once into [0, MEMBERS).
  always_comb begin
    w_sum     = {1'b0, r_idx} + {1'b0, r_step} + C_ONE_W;
    w_wrapped = (w_sum >= C_MEMBERS) ? (w_sum - C_MEMBERS) : w_sum;
  end

  // Load a fresh burst, or step to the next member on each accepted beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx  <= '0;
      r_step <= '0;
      r_rem  <= '0;
    end else if (load) begin
      r_idx  <= first;
      r_step <= step_1;
      r_rem  <= count_1;
    end else if (advance && (r_rem != '0)) begin
      r_idx  <= w_wrapped[BM-1:0];
      r_rem  <= r_rem - C_ONE;
    end
  end

  assign idx        = r_idx;
  assign final_beat = (r_rem == '0);

endmodule

`default_nettype wire

// File: rtl/axis_dw_serializer.sv
// ============================================================================
// Module      : axis_dw_serializer
// Description : Splits one wide AXI-Stream beat (MEMBERS groups of UNITS
//               words) into a burst of narrow beats, one member per beat,
//               visiting members with a modular stride.
//               Optional macro DW_SERIALIZER_DOUBLE_BUF_EN adds a second
//               input register so the next beat can be taken during a burst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_dw_serializer
  import dw_serializer_pkg::*;
#(
  parameter int WORD_WIDTH      = 32,
  parameter int UNITS           = 8,
  parameter int MEMBERS         = 12,
  parameter int CLR_WIDTH       = 4,
  parameter int USER_BASE_WIDTH = 8,
  parameter int BM              = dw_bm(MEMBERS),
  parameter int S_USER_WIDTH    = USER_BASE_WIDTH + 3*BM + MEMBERS*CLR_WIDTH,
  parameter int M_USER_WIDTH    = USER_BASE_WIDTH + BM + CLR_WIDTH
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic                                  s_last,
  input  logic [MEMBERS*UNITS*WORD_WIDTH-1:0]   s_data,
  input  logic [S_USER_WIDTH-1:0]               s_user,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic                                  m_last,
  output logic [UNITS*WORD_WIDTH-1:0]           m_data,
  output logic [M_USER_WIDTH-1:0]               m_user
);

  localparam int MW      = UNITS*WORD_WIDTH;
  localparam int O_FIRST = USER_BASE_WIDTH;
  localparam int O_STEP  = USER_BASE_WIDTH + BM;
  localparam int O_COUNT = USER_BASE_WIDTH + 2*BM;
  localparam int O_CLR   = USER_BASE_WIDTH + 3*BM;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic                            r_rdy_en;
  logic [MEMBERS*MW-1:0]           r_data;
  logic [USER_BASE_WIDTH-1:0]      r_base;
  logic [MEMBERS*CLR_WIDTH-1:0]    r_clr;
  logic                            r_last;
  logic                            w_load;
  logic                            w_accept;
  logic                            w_final;
  logic                            w_final_hs;
  logic [MEMBERS*MW-1:0]           w_src_data;
  logic [S_USER_WIDTH-1:0]         w_src_user;
  logic                            w_src_last;
  logic [BM-1:0]                   w_idx;
  logic [CLR_WIDTH-1:0]            w_clr_sel;

`ifdef DW_SERIALIZER_DOUBLE_BUF_EN
  logic                            r_hold_valid;
  logic [MEMBERS*MW-1:0]           r_hold_data;
  logic [S_USER_WIDTH-1:0]         r_hold_user;
  logic                            r_hold_last;
  logic                            w_direct;
  logic                            w_promote;
`endif

  assign m_valid    = (r_state == DRAIN);
  assign w_final_hs = m_valid && m_ready && w_final;

  // Keeps s_ready low while reset is asserted and until the first clock after.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rdy_en <= 1'b0;
    else          r_rdy_en <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Input acceptance, working-register load source and next state.
  always_comb begin
    w_state_nxt = r_state;
    w_src_data  = s_data;
    w_src_user  = s_user;
    w_src_last  = s_last;
`ifdef DW_SERIALIZER_DOUBLE_BUF_EN
    s_ready   = r_rdy_en && !r_hold_valid;
    w_accept  = s_valid && s_ready;
    w_direct  = w_accept && ((r_state == IDLE) || w_final_hs);
    w_promote = w_final_hs && r_hold_valid;
    w_load    = w_direct || w_promote;
    if (w_promote) begin
      w_src_data = r_hold_data;
      w_src_user = r_hold_user;
      w_src_last = r_hold_last;
    end
`else
    s_ready  = r_rdy_en && ((r_state == IDLE) || w_final_hs);
    w_accept = s_valid && s_ready;
    w_load   = w_accept;
`endif
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = DRAIN;
      DRAIN:   if (w_final_hs && !w_load) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef DW_SERIALIZER_DOUBLE_BUF_EN
  // Second input register: parks a beat taken mid-burst until the burst ends.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_hold_user  <= '0;
      r_hold_last  <= 1'b0;
    end else if (w_accept && !w_direct) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= s_data;
      r_hold_user  <= s_user;
      r_hold_last  <= s_last;
    end else if (w_promote) begin
      r_hold_valid <= 1'b0;
    end
  end
`endif

  // Working register: the beat being serialized; base/last fixed per burst.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_data <= '0;
      r_base <= '0;
      r_clr  <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      r_data <= w_src_data;
      r_base <= w_src_user[USER_BASE_WIDTH-1:0];
      r_clr  <= w_src_user[O_CLR +: MEMBERS*CLR_WIDTH];
      r_last <= w_src_last;
    end
  end

  dw_index_gen #(
    .MEMBERS    (MEMBERS),
    .BM         (BM)
  ) u_index_gen (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .load       (w_load),
    .first      (w_src_user[O_FIRST +: BM]),
    .step_1     (w_src_user[O_STEP +: BM]),
    .count_1    (w_src_user[O_COUNT +: BM]),
    .advance    (m_valid && m_ready),
    .idx        (w_idx),
    .final_beat (w_final)
  );

  // Member select; an index outside [0, MEMBERS) yields zeros.
  always_comb begin
    m_data    = '0;
    w_clr_sel = '0;
    for (int m = 0; m < MEMBERS; m++) begin
      if (w_idx == BM'(m)) begin
        m_data    = r_data[m*MW +: MW];
        w_clr_sel = r_clr[m*CLR_WIDTH +: CLR_WIDTH];
      end
    end
  end

  assign m_user = {w_clr_sel, w_idx, r_base};
  assign m_last = m_valid && r_last && w_final;

endmodule

`default_nettype wire

// File: tb/tb_axis_dw_serializer.sv
// ============================================================================
// Module      : tb_axis_dw_serializer
// Description : Directed self-checking bench for axis_dw_serializer at the
//               default geometry (12 members x 8 words x 32 bits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_dw_serializer;
  import dw_serializer_pkg::*;

  logic         aclk;
  logic         aresetn;
  logic         s_valid;
  logic         s_ready;
  logic         s_last;
  logic [3071:0] s_data;
  s_user_t      su;
  logic [67:0]  s_user;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic [255:0] m_data;
  logic [15:0]  m_user;

  int total = 0;
  int bad   = 0;

  axis_dw_serializer dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_data  (s_data),
    .s_user  (s_user),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .m_data  (m_data),
    .m_user  (m_user)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  assign s_user = su;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_data(input int m);
    logic [255:0] r;
    for (int u = 0; u < 8; u++) r[u*32 +: 32] = 32'(m*10 + u + 1);
    return r;
  endfunction

  function automatic logic [255:0] exp_user(input int m);
    logic [15:0] r;
    r = {4'(m + 1), 4'(m), 8'hA5};
    return 256'(r);
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_beat(input int first, input int step, input int cnt, input logic last);
    su.first   = 4'(first);
    su.step_1  = 4'(step);
    su.count_1 = 4'(cnt);
    s_last     = last;
  endtask

  // Present one beat in IDLE, hand it over, and leave s_valid low.
  task automatic send(input string tag, input int first, input int step, input int cnt,
                      input logic last);
    set_beat(first, step, cnt, last);
    s_valid = 1'b1;
    chk({tag, "_s_ready_idle"}, 256'(s_ready), 256'(1'b1));
    tick();
    s_valid = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int m, input logic last);
    chk({tag, "_valid"}, 256'(m_valid), 256'(1'b1));
    chk({tag, "_data"},  m_data, exp_data(m));
    chk({tag, "_user"},  256'(m_user), exp_user(m));
    chk({tag, "_last"},  256'(m_last), 256'(last));
  endtask

  initial begin
    int exp_idx [4];
    int pat [8];
    int ptr;
    int cyc;

    aresetn = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    s_last  = 1'b0;
    su      = '0;
    su.base = 8'hA5;
    for (int m = 0; m < 12; m++) begin
      su.clr[m] = 4'(m + 1);
      for (int u = 0; u < 8; u++) s_data[(m*8 + u)*32 +: 32] = 32'(m*10 + u + 1);
    end

    // Reset state.
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_m_valid", 256'(m_valid), 256'(1'b0));
    chk("rst_m_last",  256'(m_last),  256'(1'b0));
    chk("rst_m_data",  m_data,        256'(0));
    chk("rst_m_user",  256'(m_user),  256'(0));
    chk("rst_s_ready", 256'(s_ready), 256'(1'b0));
    aresetn = 1'b1;
    tick();
    chk("rel_s_ready", 256'(s_ready), 256'(1'b1));

    // Single beat, member 11, last.
    send("single", 11, 0, 0, 1'b1);
    check_beat("single_b0", 11, 1'b1);
    tick();
    chk("single_idle", 256'(m_valid), 256'(1'b0));

    // Stride 3, four beats.
    send("stride", 0, 2, 3, 1'b1);
    chk("stride_s_ready_drain", 256'(s_ready), 256'(1'b0));
    check_beat("stride_b0", 0, 1'b0); tick();
    check_beat("stride_b1", 3, 1'b0); tick();
    check_beat("stride_b2", 6, 1'b0); tick();
    check_beat("stride_b3", 9, 1'b1); tick();
    chk("stride_idle", 256'(m_valid), 256'(1'b0));

    // Wrap: 10 -> 2 -> 6, no last since s_last=0.
    send("wrap", 10, 3, 2, 1'b0);
    check_beat("wrap_b0", 10, 1'b0); tick();
    check_beat("wrap_b1", 2, 1'b0);  tick();
    check_beat("wrap_b2", 6, 1'b0);  tick();
    chk("wrap_idle", 256'(m_valid), 256'(1'b0));

    // Backpressure on the stride burst.
    exp_idx = '{0, 3, 6, 9};
    pat     = '{1, 0, 0, 0, 0, 1, 1, 0};
    send("stall", 0, 2, 3, 1'b1);
    ptr = 0;
    cyc = 0;
    while (ptr < 4 && cyc < 20) begin
      m_ready = (cyc < 8) ? pat[cyc][0] : 1'b1;
      check_beat("stall_beat", exp_idx[ptr], (ptr == 3));
      @(posedge aclk);
      if (m_ready) ptr++;
      #1;
      cyc++;
    end
    m_ready = 1'b1;
    chk("stall_count", 256'(ptr), 256'(4));
    chk("stall_cycles", 256'(cyc), 256'(9));
    chk("stall_idle", 256'(m_valid), 256'(1'b0));

    // Back-to-back: burst A (0,1,last) then B (5,7) with s_valid held.
    set_beat(0, 0, 1, 1'b1);
    s_valid = 1'b1;
    tick();
    set_beat(5, 1, 1, 1'b0);
`ifndef DW_SERIALIZER_DOUBLE_BUF_EN
    chk("b2b_s_ready_mid", 256'(s_ready), 256'(1'b0));
`endif
    check_beat("b2b_a0", 0, 1'b0); tick();
`ifndef DW_SERIALIZER_DOUBLE_BUF_EN
    chk("b2b_s_ready_final", 256'(s_ready), 256'(1'b1));
`endif
    check_beat("b2b_a1", 1, 1'b1); tick();
    s_valid = 1'b0;
    check_beat("b2b_b0", 5, 1'b0); tick();
    check_beat("b2b_b1", 7, 1'b0); tick();
    chk("b2b_idle", 256'(m_valid), 256'(1'b0));

    // Reset during the second beat of a 4-beat burst.
    send("rstmid", 0, 2, 3, 1'b1);
    check_beat("rstmid_b0", 0, 1'b0); tick();
    check_beat("rstmid_b1", 3, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("rstmid_m_valid", 256'(m_valid), 256'(1'b0));
    chk("rstmid_s_ready", 256'(s_ready), 256'(1'b0));
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tick();
    chk("rstmid_rel_s_ready", 256'(s_ready), 256'(1'b1));
    chk("rstmid_rel_m_valid", 256'(m_valid), 256'(1'b0));
    tick();
    chk("rstmid_no_resume", 256'(m_valid), 256'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
